bus_mn: RTL and testbench
=========================

BUS_MN -- requirements
Module: bus_mn

Interface
REQ-001 Parameter NUM_M, default 2: number of masters, range 2..8.
REQ-002 Parameter NUM_S, default 4: number of slaves, range 1..2^(ADDR_W-REGION_BITS).
REQ-003 Parameter ADDR_W, default 8: address width.
REQ-004 Parameter DATA_W, default 32: data width.
REQ-005 Parameter REGION_BITS, default 5: log2 of the per-slave region size, so each region is 0x20 bytes.
REQ-006 clk  input  1: single clock; all state updates on the rising edge.
REQ-007 reset  input  1: synchronous, active-high reset.
REQ-008 M_req  input  NUM_M: per-master bus request.
REQ-009 M_wr  input  NUM_M: per-master write enable (1 = write, 0 = read).
REQ-010 M_addr  input  NUM_M*ADDR_W: per-master address; master i occupies slice i.
REQ-011 M_dout  input  NUM_M*DATA_W: per-master write data.
REQ-012 S_dout  input  NUM_S*DATA_W: per-slave read data.
REQ-013 M_grant  output  NUM_M: one-hot or zero; registered.
REQ-014 M_din  output  DATA_W: read data returned to the masters.
REQ-015 M_err  output  1: registered decode-error pulse.
REQ-016 S_sel  output  NUM_S: one-hot or zero slave select.
REQ-017 S_addr  output  ADDR_W: address of the owning master.
REQ-018 S_wr  output  1: write enable of the owning master.
REQ-019 S_din  output  DATA_W: write data of the owning master.

Function
REQ-020 The arbiter SHALL have two states: IDLE (no owner) and OWNED (exactly one M_grant bit set).
REQ-021 At each edge in IDLE, if any M_req is high, the arbiter SHALL grant the round-robin winner, searching upward from last_owner+1 modulo NUM_M, and enter OWNED.
REQ-022 At each edge in OWNED, if the owner's M_req is high, the grant SHALL be held with no preemption.
REQ-023 At each edge in OWNED, if the owner's M_req is low, the grant SHALL pass directly to the next round-robin requester, or the arbiter SHALL return to IDLE with M_grant = 0 if there is none.
REQ-024 last_owner SHALL update on every new grant.
REQ-025 Grant latency SHALL be 1 cycle from request to M_grant.
REQ-026 S_addr, S_wr and S_din SHALL combinationally follow the owning master's slice.
REQ-027 S_addr, S_wr and S_din SHALL all be 0 when there is no owner.
REQ-028 Decode: S_sel[k] SHALL be 1 iff there is an owner, the owner's M_req is high, and S_addr[ADDR_W-1:REGION_BITS] == k with k < NUM_S.
REQ-029 An owned access whose region index is >= NUM_S is unmapped: S_sel SHALL be 0, and M_err SHALL be 1 for exactly the following cycle.
REQ-030 Read path: sel_q SHALL register S_sel each cycle.
REQ-031 M_din SHALL equal the S_dout slice selected by sel_q, or 0 when sel_q is 0, giving 1-cycle read latency.
REQ-032 S_sel SHALL be driven for writes as well; M_din is don't-care after a write.
REQ-033 Simultaneous owner release and new request SHALL cause no idle cycle; the handover completes in the same edge.
REQ-034 Address changes while ownership is held SHALL take effect combinationally on S_sel.

Reset
REQ-035 While reset is high at an edge, the block SHALL clear M_grant, sel_q and M_err to 0.
REQ-036 Reset SHALL force state to IDLE and last_owner to NUM_M-1, so master 0 wins first.
REQ-037 Reset asserted mid-transfer SHALL drop the grant on that edge, with S_sel = 0 on the following cycle.
REQ-038 Outputs SHALL be 0 for every cycle in which reset is sampled high.

Structure
REQ-039 The package bus_pkg SHALL hold the parameter defaults and the arbiter state enum (IDLE, OWNED).
REQ-040 The sub-module bus_rr_arbiter SHALL contain the request/grant round-robin logic and last_owner.
REQ-041 bus_mn SHALL contain the decode, the data muxes, sel_q and M_err.
REQ-042 The target size is 120-400 lines of RTL in total.

Verification
REQ-043 Single master: M_req[0]=1, M_wr=0, addr 0x03, S_dout0=0x00000007 -> M_grant=01 after 1 cycle; S_sel=0001; M_din=0x00000007 one cycle later.
REQ-044 Contention: M_req=11 from IDLE after reset -> master 0 is granted; master 0 drops its request -> M_grant=10 on the next edge with no idle cycle; master 1 drops its request, then both request again -> master 0 is granted.
REQ-045 Decode: owner addr 0x31 -> S_sel=0010; addr 0x65 -> 1000; NUM_S=2 with addr 0x65 -> S_sel=00 and M_err=1 for one cycle, then 0.
REQ-046 Write: master 1 owns, M_wr=1, addr 0x24, M_dout1=0x00000005 -> S_wr=1, S_addr=0x24, S_din=0x00000005, S_sel=0010.
REQ-047 Reset mid-transfer: reset=1 while master 1 is reading -> M_grant=00, M_din=0 and M_err=0 at the next cycle; after reset=0 with M_req=11 -> master 0 is granted.
REQ-048 Parameter sweep: NUM_M=3 and NUM_S=4 with all masters requesting and each releasing after 2 cycles -> grant order 0, 1, 2, 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared defaults and arbiter state type for the multi-master bus.
package bus_pkg;
    localparam int NUM_M_DEF       = 2;
    localparam int NUM_S_DEF       = 4;
    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 32;
    localparam int REGION_BITS_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;
endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: grant is held while the owner keeps requesting and
// passes straight to the next requester (or idles) when the owner releases.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M = NUM_M_DEF,
    parameter int OW    = $clog2(NUM_M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] req,
    output logic [NUM_M-1:0] grant,
    output logic             owned,
    output logic [OW-1:0]    owner
);

    arb_state_t       state_reg, state_next;
    logic [OW-1:0]    owner_reg, owner_next;
    logic [OW-1:0]    last_reg, last_next;
    logic [NUM_M-1:0] grant_reg, grant_next;
    logic [OW-1:0]    winner;
    logic [OW-1:0]    cand;
    logic             found;

    // last_reg equals owner_reg whenever OWNED, so one upward search from
    // last_owner+1 serves both the idle grant and the release handover.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = OW'((int'(last_reg) + i) % NUM_M);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        grant_next = '0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = OWNED;
                    owner_next = winner;
                    last_next  = winner;
                end
            end
            OWNED: begin
                if (!req[owner_reg]) begin
                    if (found) begin
                        owner_next = winner;
                        last_next  = winner;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == OWNED) begin
            grant_next[owner_next] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            last_reg  <= OW'(NUM_M - 1);
            grant_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            grant_reg <= grant_next;
        end
    end

    assign grant = grant_reg;
    assign owned = (state_reg == OWNED);
    assign owner = owner_reg;

endmodule

// File: rtl/bus_mn.sv
// Multi-master bus: round-robin arbitration, address-region slave decode,
// owner-driven slave signals and a registered read-data return path.
module bus_mn
    import bus_pkg::*;
#(
    parameter int NUM_M       = NUM_M_DEF,
    parameter int NUM_S       = NUM_S_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REGION_BITS = REGION_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_M-1:0]        M_req,
    input  logic [NUM_M-1:0]        M_wr,
    input  logic [NUM_M*ADDR_W-1:0] M_addr,
    input  logic [NUM_M*DATA_W-1:0] M_dout,
    input  logic [NUM_S*DATA_W-1:0] S_dout,
    output logic [NUM_M-1:0]        M_grant,
    output logic [DATA_W-1:0]       M_din,
    output logic                    M_err,
    output logic [NUM_S-1:0]        S_sel,
    output logic [ADDR_W-1:0]       S_addr,
    output logic                    S_wr,
    output logic [DATA_W-1:0]       S_din
);

    localparam int OW = $clog2(NUM_M);
    localparam int RW = ADDR_W - REGION_BITS;

    logic              owned;
    logic [OW-1:0]     owner;
    logic [ADDR_W-1:0] addr_arr [NUM_M];
    logic [DATA_W-1:0] wdata_arr [NUM_M];
    logic [DATA_W-1:0] rdata_arr [NUM_S];
    logic              access;
    logic [RW-1:0]     region;
    logic              unmapped;
    logic [NUM_S-1:0]  sel_q;
    logic              err_reg;

    bus_rr_arbiter #(
        .NUM_M (NUM_M),
        .OW    (OW)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (M_req),
        .grant (M_grant),
        .owned (owned),
        .owner (owner)
    );

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_mslice
        assign addr_arr[gi]  = M_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = M_dout[gi*DATA_W +: DATA_W];
    end

    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_sslice
        assign rdata_arr[gi] = S_dout[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        S_addr = '0;
        S_wr   = 1'b0;
        S_din  = '0;
        if (owned) begin
            S_addr = addr_arr[owner];
            S_wr   = M_wr[owner];
            S_din  = wdata_arr[owner];
        end
    end

    // A slave is only selected while the owner is still actively requesting.
    assign access   = owned && M_req[owner];
    assign region   = S_addr[ADDR_W-1:REGION_BITS];
    assign unmapped = access && ({1'b0, region} >= (RW+1)'(NUM_S));

    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_decode
        assign S_sel[gi] = access && (region == RW'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            err_reg <= 1'b0;
        end else begin
            sel_q   <= S_sel;
            err_reg <= unmapped;
        end
    end

    always_comb begin
        M_din = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (sel_q[k]) begin
                M_din = M_din | rdata_arr[k];
            end
        end
    end

    assign M_err = err_reg;

endmodule

// File: tb/tb_bus_mn.sv
// Bench for bus_mn: directed vector table, decode/parameter corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_bus_mn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- default instance (2 masters, 4 slaves)
    logic         rst_a;
    logic [1:0]   a_req, a_wr, a_grant;
    logic [15:0]  a_addr;
    logic [63:0]  a_dout;
    logic [127:0] a_sdout;
    logic [31:0]  a_din, a_sdin;
    logic         a_err, a_swr;
    logic [3:0]   a_sel;
    logic [7:0]   a_saddr;

    bus_mn dut (
        .clk(clk), .reset(rst_a), .M_req(a_req), .M_wr(a_wr), .M_addr(a_addr),
        .M_dout(a_dout), .S_dout(a_sdout), .M_grant(a_grant), .M_din(a_din),
        .M_err(a_err), .S_sel(a_sel), .S_addr(a_saddr), .S_wr(a_swr), .S_din(a_sdin)
    );

    // ---------------- two slaves only (upper regions unmapped)
    logic         rst_b;
    logic [1:0]   b_req, b_wr, b_grant;
    logic [15:0]  b_addr;
    logic [63:0]  b_dout, b_sdout;
    logic [31:0]  b_din, b_sdin;
    logic         b_err, b_swr;
    logic [1:0]   b_sel;
    logic [7:0]   b_saddr;

    bus_mn #(.NUM_M(2), .NUM_S(2)) dut_b (
        .clk(clk), .reset(rst_b), .M_req(b_req), .M_wr(b_wr), .M_addr(b_addr),
        .M_dout(b_dout), .S_dout(b_sdout), .M_grant(b_grant), .M_din(b_din),
        .M_err(b_err), .S_sel(b_sel), .S_addr(b_saddr), .S_wr(b_swr), .S_din(b_sdin)
    );

    // ---------------- three masters
    logic         rst_c;
    logic [2:0]   c_req, c_wr, c_grant;
    logic [23:0]  c_addr;
    logic [95:0]  c_dout;
    logic [127:0] c_sdout;
    logic [31:0]  c_din, c_sdin;
    logic         c_err, c_swr;
    logic [3:0]   c_sel;
    logic [7:0]   c_saddr;

    bus_mn #(.NUM_M(3), .NUM_S(4)) dut_c (
        .clk(clk), .reset(rst_c), .M_req(c_req), .M_wr(c_wr), .M_addr(c_addr),
        .M_dout(c_dout), .S_dout(c_sdout), .M_grant(c_grant), .M_din(c_din),
        .M_err(c_err), .S_sel(c_sel), .S_addr(c_saddr), .S_wr(c_swr), .S_din(c_sdin)
    );

    // One row = inputs held for a cycle; expected = outputs just after that edge.
    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] wr;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [1:0] grant;
        logic [3:0] sel;
        logic [7:0] saddr;
        logic       swr;
        logic [31:0] sdin;
        logic [31:0] din;
        logic       err;
    } vec_t;

    vec_t tbl [16];

    // Behavioural model: owner as an integer (-1 = none) plus last owner.
    function automatic logic [3:0] sel_of(input int own, input logic [1:0] rq,
                                          input logic [15:0] ad, output logic unm);
        logic [7:0] a;
        sel_of = 4'b0000;
        unm    = 1'b0;
        if (own >= 0 && rq[own]) begin
            a = ad[own*8 +: 8];
            if (a / 32 < 4) sel_of = 4'b0001 << (a / 32);
            else            unm    = 1'b1;
        end
    endfunction

    int          m_owner, m_last, nxt, c_cur, c_hold, n_order, gi_c;
    logic [3:0]  m_selq, pre_sel, exp_sel;
    logic        m_err, unm, unm_dummy;
    logic [31:0] exp_din;
    int          order [4];
    int          exp_order [4];

    initial begin
        tbl[0]  = '{1'b1, 2'b00, 2'b00, 8'h03, 8'h24, 2'b00, 4'b0000, 8'h00, 1'b0, 32'h00, 32'h00, 1'b0};
        tbl[1]  = '{1'b0, 2'b01, 2'b00, 8'h03, 8'h24, 2'b01, 4'b0001, 8'h03, 1'b0, 32'hA0, 32'h00, 1'b0};
        tbl[2]  = '{1'b0, 2'b01, 2'b00, 8'h03, 8'h24, 2'b01, 4'b0001, 8'h03, 1'b0, 32'hA0, 32'h07, 1'b0};
        tbl[3]  = '{1'b0, 2'b01, 2'b00, 8'h31, 8'h24, 2'b01, 4'b0010, 8'h31, 1'b0, 32'hA0, 32'h11, 1'b0};
        tbl[4]  = '{1'b0, 2'b01, 2'b00, 8'h65, 8'h24, 2'b01, 4'b1000, 8'h65, 1'b0, 32'hA0, 32'h33, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 2'b00, 8'h03, 8'h24, 2'b01, 4'b0001, 8'h03, 1'b0, 32'hA0, 32'h07, 1'b0};
        tbl[6]  = '{1'b0, 2'b10, 2'b10, 8'h03, 8'h24, 2'b10, 4'b0010, 8'h24, 1'b1, 32'h05, 32'h00, 1'b0};
        tbl[7]  = '{1'b0, 2'b10, 2'b10, 8'h03, 8'h24, 2'b10, 4'b0010, 8'h24, 1'b1, 32'h05, 32'h11, 1'b0};
        tbl[8]  = '{1'b0, 2'b00, 2'b00, 8'h03, 8'h24, 2'b00, 4'b0000, 8'h00, 1'b0, 32'h00, 32'h00, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 2'b00, 8'h03, 8'h24, 2'b01, 4'b0001, 8'h03, 1'b0, 32'hA0, 32'h00, 1'b0};
        tbl[10] = '{1'b0, 2'b10, 2'b00, 8'h03, 8'h24, 2'b10, 4'b0010, 8'h24, 1'b0, 32'h05, 32'h00, 1'b0};
        tbl[11] = '{1'b0, 2'b10, 2'b00, 8'h03, 8'h24, 2'b10, 4'b0010, 8'h24, 1'b0, 32'h05, 32'h11, 1'b0};
        tbl[12] = '{1'b1, 2'b10, 2'b00, 8'h03, 8'h24, 2'b00, 4'b0000, 8'h00, 1'b0, 32'h00, 32'h00, 1'b0};
        tbl[13] = '{1'b0, 2'b11, 2'b00, 8'h03, 8'h24, 2'b01, 4'b0001, 8'h03, 1'b0, 32'hA0, 32'h00, 1'b0};
        tbl[14] = '{1'b0, 2'b01, 2'b00, 8'hE5, 8'h24, 2'b01, 4'b0000, 8'hE5, 1'b0, 32'hA0, 32'h00, 1'b1};
        tbl[15] = '{1'b0, 2'b01, 2'b00, 8'h03, 8'h24, 2'b01, 4'b0001, 8'h03, 1'b0, 32'hA0, 32'h07, 1'b0};
        exp_order = '{0, 1, 2, 0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        a_req = '0; a_wr = '0; a_addr = '0; a_dout = {32'h05, 32'hA0};
        a_sdout = {32'h33, 32'h22, 32'h11, 32'h07};
        b_req = '0; b_wr = '0; b_addr = '0; b_dout = '0; b_sdout = {32'hBB, 32'hAA};
        c_req = '0; c_wr = '0; c_addr = '0; c_dout = '0; c_sdout = '0;
        repeat (2) @(posedge clk);

        // Directed table on the default instance
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst_a  = tbl[i].rst;
            a_req  = tbl[i].req;
            a_wr   = tbl[i].wr;
            a_addr = {tbl[i].a1, tbl[i].a0};
            @(posedge clk); #1;
            chk($sformatf("row%0d grant", i), 64'(a_grant), 64'(tbl[i].grant));
            chk($sformatf("row%0d sel",   i), 64'(a_sel),   64'(tbl[i].sel));
            chk($sformatf("row%0d saddr", i), 64'(a_saddr), 64'(tbl[i].saddr));
            chk($sformatf("row%0d swr",   i), 64'(a_swr),   64'(tbl[i].swr));
            chk($sformatf("row%0d sdin",  i), 64'(a_sdin),  64'(tbl[i].sdin));
            chk($sformatf("row%0d din",   i), 64'(a_din),   64'(tbl[i].din));
            chk($sformatf("row%0d err",   i), 64'(a_err),   64'(tbl[i].err));
            $display("vec %0d: req=%b grant=%b sel=%b din=%h err=%b", i, a_req, a_grant, a_sel, a_din, a_err);
        end

        // Unmapped region with two slaves: one-cycle error pulse
        @(negedge clk); rst_b = 1'b0; b_req = 2'b01; b_addr = 16'h0065;
        @(posedge clk); #1;
        chk("b grant", 64'(b_grant), 64'h1);
        chk("b sel unmapped", 64'(b_sel), 64'h0);
        chk("b err before", 64'(b_err), 64'h0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("b err pulse", 64'(b_err), 64'h1);
        chk("b sel still 0", 64'(b_sel), 64'h0);
        @(negedge clk); b_addr = 16'h0003;
        @(posedge clk); #1;
        chk("b err cleared", 64'(b_err), 64'h0);
        chk("b sel mapped", 64'(b_sel), 64'h1);
        chk("b din", 64'(b_din), 64'hAA);
        $display("seq b: grant=%b sel=%b err=%b din=%h", b_grant, b_sel, b_err, b_din);

        // Three masters, each releasing after two granted cycles
        rst_c = 1'b0; c_cur = -1; c_hold = 0; n_order = 0;
        for (int cyc = 0; cyc < 12 && n_order < 4; cyc++) begin
            @(negedge clk);
            c_req = 3'b111;
            if (c_cur >= 0 && c_hold >= 2) c_req[c_cur] = 1'b0;
            @(posedge clk); #1;
            chk("c err", 64'(c_err), 64'h0);
            case (c_grant)
                3'b001:  gi_c = 0;
                3'b010:  gi_c = 1;
                3'b100:  gi_c = 2;
                default: gi_c = -1;
            endcase
            chk("c grant onehot", 64'(gi_c >= 0), 64'h1);
            if (gi_c != c_cur) begin
                if (n_order < 4) order[n_order] = gi_c;
                n_order++;
                c_cur  = gi_c;
                c_hold = 1;
            end else begin
                c_hold++;
            end
            $display("seq c: req=%b grant=%b", c_req, c_grant);
        end
        chk("c grants seen", 64'(n_order), 64'h4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("c order%0d", i), 64'(order[i]), 64'(exp_order[i]));
        end

        // Randomized traffic against the model; first cycle forces reset
        m_owner = -1; m_last = 1; m_selq = '0; m_err = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            rst_a   = (t == 0) || ($urandom_range(0, 24) == 0);
            a_req   = 2'($urandom_range(0, 3));
            a_wr    = 2'($urandom_range(0, 3));
            a_addr  = 16'($urandom);
            a_dout  = {$urandom, $urandom};
            a_sdout = {$urandom, $urandom, $urandom, $urandom};
            pre_sel = sel_of(m_owner, a_req, a_addr, unm);
            if (rst_a) begin
                m_owner = -1; m_last = 1; m_selq = '0; m_err = 1'b0;
            end else begin
                m_selq = pre_sel;
                m_err  = unm;
                if (!(m_owner >= 0 && a_req[m_owner])) begin
                    nxt = -1;
                    for (int k = 1; k <= 2; k++) begin
                        if (nxt < 0 && a_req[(m_last + k) % 2]) nxt = (m_last + k) % 2;
                    end
                    m_owner = nxt;
                    if (nxt >= 0) m_last = nxt;
                end
            end
            @(posedge clk); #1;
            exp_sel = sel_of(m_owner, a_req, a_addr, unm_dummy);
            exp_din = '0;
            for (int k = 0; k < 4; k++) if (m_selq[k]) exp_din = exp_din | a_sdout[k*32 +: 32];
            chk("rnd grant", 64'(a_grant), (m_owner >= 0) ? (64'h1 << m_owner) : 64'h0);
            chk("rnd sel",   64'(a_sel),   64'(exp_sel));
            chk("rnd saddr", 64'(a_saddr), (m_owner >= 0) ? 64'(a_addr[m_owner*8 +: 8]) : 64'h0);
            chk("rnd swr",   64'(a_swr),   (m_owner >= 0) ? 64'(a_wr[m_owner]) : 64'h0);
            chk("rnd sdin",  64'(a_sdin),  (m_owner >= 0) ? 64'(a_dout[m_owner*32 +: 32]) : 64'h0);
            chk("rnd din",   64'(a_din),   64'(exp_din));
            chk("rnd err",   64'(a_err),   64'(m_err));
            $display("rnd %0d: rst=%b req=%b grant=%b sel=%b err=%b", t, rst_a, a_req, a_grant, a_sel, a_err);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
